pong_score_keeper: RTL and testbench

- Sits directly downstream of GameLogic, on the same 50 MHz clock.
- Watches ball_x for goal-zone entry and keeps two-digit BCD scores for each player.
- Sequences the serve delay and drives four seven-segment displays (HEX7..HEX4).
- Issues a one-cycle serve request back to GameLogic and declares a winner at WIN_SCORE.

---
 rtl/pong_score_keeper_if.sv | 25 ++
 rtl/pong_score_keeper.sv | 122 ++++++++++++
 tb/tb_pong_score_keeper.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pong_score_keeper_if.sv
// pong_score_keeper_if: ball position, restart and score/display bundle between GameLogic and the score keeper
interface pong_score_keeper_if;
  logic [9:0] ball_x;
  logic       new_game;
  logic       serve_req;
  logic       serve_dir;
  logic [7:0] score_left;
  logic [7:0] score_right;
  logic       game_over;
  logic       winner;
  logic [6:0] hex_l1;
  logic [6:0] hex_l0;
  logic [6:0] hex_r1;
  logic [6:0] hex_r0;
  modport master (
    output ball_x, new_game,
    input  serve_req, serve_dir, score_left, score_right, game_over, winner,
           hex_l1, hex_l0, hex_r1, hex_r0
  );
  modport slave (
    input  ball_x, new_game,
    output serve_req, serve_dir, score_left, score_right, game_over, winner,
           hex_l1, hex_l0, hex_r1, hex_r0
  );
endinterface

// File: rtl/pong_score_keeper.sv
// pong_score_keeper: goal detection, BCD scoring, serve sequencing and seven-segment display for pong
module pong_score_keeper #(
  parameter int GOAL_L      = 4,
  parameter int GOAL_R      = 628,
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_DELAY = 50000000
) (
  input logic clk,
  input logic rst_n,
  pong_score_keeper_if.slave bus
);
  localparam int CW = SERVE_DELAY > 1 ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CW-1:0] LAST = CW'(SERVE_DELAY - 1);
  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  typedef enum logic [1:0] {WAIT, SERVE, PLAY, OVER} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0] sl, sl_d, sr, sr_d, sl_inc, sr_inc;
  logic dir, dir_d, win, win_d, zl_q, zr_q, in_l, in_r, goal_l, goal_r, sreq;
  logic [6:0] hl1, hl0, hr1, hr0;
  function automatic logic [7:0] bcd_inc(input logic [7:0] x);
    return x == 8'h99 ? x : x[3:0] == 4'd9 ? {x[7:4] + 4'd1, 4'd0} : {x[7:4], x[3:0] + 4'd1};
  endfunction
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction
  assign in_l   = bus.ball_x <= 10'(GOAL_L);
  assign in_r   = bus.ball_x >= 10'(GOAL_R);
  assign goal_l = in_l & ~zl_q;
  assign goal_r = in_r & ~zr_q;
  assign sl_inc = bcd_inc(sl);
  assign sr_inc = bcd_inc(sr);
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sl_d    = sl;
    sr_d    = sr;
    dir_d   = dir;
    win_d   = win;
    if (bus.new_game) begin
      state_d = WAIT;
      cnt_d   = '0;
      sl_d    = '0;
      sr_d    = '0;
      dir_d   = 1'b0;
      win_d   = 1'b0;
    end else begin
      case (state)
        WAIT: begin
          cnt_d   = cnt == LAST ? '0 : cnt + 1'b1;
          state_d = cnt == LAST ? SERVE : WAIT;
        end
        SERVE: state_d = PLAY;
        PLAY: begin
          if (goal_l) begin
            sr_d    = sr_inc;
            dir_d   = 1'b0;
            state_d = sr_inc == WIN_BCD ? OVER : WAIT;
            win_d   = sr_inc == WIN_BCD ? 1'b1 : win;
          end else if (goal_r) begin
            sl_d    = sl_inc;
            dir_d   = 1'b1;
            state_d = sl_inc == WIN_BCD ? OVER : WAIT;
            win_d   = sl_inc == WIN_BCD ? 1'b0 : win;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    zl_q <= in_l;
    zr_q <= in_r;
    if (!rst_n) begin
      state <= WAIT;
      cnt   <= '0;
      sl    <= '0;
      sr    <= '0;
      dir   <= 1'b0;
      win   <= 1'b0;
      sreq  <= 1'b0;
      hl1   <= 7'b1111111;
      hl0   <= 7'b1000000;
      hr1   <= 7'b1111111;
      hr0   <= 7'b1000000;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sl    <= sl_d;
      sr    <= sr_d;
      dir   <= dir_d;
      win   <= win_d;
      sreq  <= state == SERVE && !bus.new_game;
      hl1   <= sl[7:4] == 4'd0 ? 7'b1111111 : seg7(sl[7:4]);
      hl0   <= seg7(sl[3:0]);
      hr1   <= sr[7:4] == 4'd0 ? 7'b1111111 : seg7(sr[7:4]);
      hr0   <= seg7(sr[3:0]);
    end
  end
  assign bus.serve_req   = sreq;
  assign bus.serve_dir   = dir;
  assign bus.score_left  = sl;
  assign bus.score_right = sr;
  assign bus.game_over   = state == OVER;
  assign bus.winner      = win;
  assign bus.hex_l1      = hl1;
  assign bus.hex_l0      = hl0;
  assign bus.hex_r1      = hr1;
  assign bus.hex_r0      = hr0;
endmodule

// File: tb/tb_pong_score_keeper.sv
// tb_pong_score_keeper: directed table, corner sequences and random play against a scoring model
module tb_pong_score_keeper;
  localparam int SD = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ng = 1'b0;
  logic [9:0] bx = 10'd320;
  int n_checks = 0;
  int n_errors = 0;
  always #10 clk = ~clk;
  pong_score_keeper_if ia();
  pong_score_keeper_if ib();
  assign ia.ball_x = bx;
  assign ia.new_game = ng;
  assign ib.ball_x = bx;
  assign ib.new_game = ng;
  pong_score_keeper #(.WIN_SCORE(11), .SERVE_DELAY(SD)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  pong_score_keeper #(.WIN_SCORE(3), .SERVE_DELAY(SD)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int m_w [2] = '{11, 3};
  int m_sl [2], m_sr [2], m_mode [2], m_cnt [2], m_hl [2], m_hr [2];
  bit m_dir [2], m_win [2], m_zl [2], m_zr [2], m_sreq [2];
  bit valid = 1'b0;
  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction
  function automatic logic [6:0] tens(input int n);
    return n / 10 == 0 ? 7'h7f : seg_tab[n / 10];
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit il = bx <= 10'd4;
      bit ir = bx >= 10'd628;
      bit gl = il && !m_zl[k];
      bit gr = ir && !m_zr[k];
      if (!rst_n) begin
        m_mode[k] = 0; m_cnt[k] = 0; m_sl[k] = 0; m_sr[k] = 0;
        m_dir[k] = 0; m_win[k] = 0; m_sreq[k] = 0; m_hl[k] = 0; m_hr[k] = 0;
      end else begin
        m_hl[k] = m_sl[k];
        m_hr[k] = m_sr[k];
        m_sreq[k] = m_mode[k] == 1 && !ng;
        if (ng) begin
          m_mode[k] = 0; m_cnt[k] = 0; m_sl[k] = 0; m_sr[k] = 0; m_dir[k] = 0; m_win[k] = 0;
        end else if (m_mode[k] == 0) begin
          m_cnt[k]++;
          if (m_cnt[k] == SD) begin
            m_cnt[k] = 0;
            m_mode[k] = 1;
          end
        end else if (m_mode[k] == 1) begin
          m_mode[k] = 2;
        end else if (m_mode[k] == 2 && gl) begin
          m_sr[k]++;
          m_dir[k] = 0;
          m_mode[k] = m_sr[k] == m_w[k] ? 3 : 0;
          if (m_sr[k] == m_w[k]) m_win[k] = 1;
        end else if (m_mode[k] == 2 && gr) begin
          m_sl[k]++;
          m_dir[k] = 1;
          m_mode[k] = m_sl[k] == m_w[k] ? 3 : 0;
          if (m_sl[k] == m_w[k]) m_win[k] = 0;
        end
      end
      m_zl[k] = il;
      m_zr[k] = ir;
    end
    if (!rst_n) valid = 1'b1;
  endtask
  task automatic check_dut(input string p, input int k, input logic sreq, input logic dir,
                           input logic [7:0] sl, input logic [7:0] sr, input logic go, input logic win,
                           input logic [6:0] l1, input logic [6:0] l0, input logic [6:0] r1, input logic [6:0] r0);
    chk({p, "serve_req"}, sreq, m_sreq[k]);
    chk({p, "serve_dir"}, dir, m_dir[k]);
    chk({p, "score_left"}, sl, bcd(m_sl[k]));
    chk({p, "score_right"}, sr, bcd(m_sr[k]));
    chk({p, "game_over"}, go, m_mode[k] == 3);
    chk({p, "winner"}, win, m_win[k]);
    chk({p, "hex_l1"}, l1, tens(m_hl[k]));
    chk({p, "hex_l0"}, l0, seg_tab[m_hl[k] % 10]);
    chk({p, "hex_r1"}, r1, tens(m_hr[k]));
    chk({p, "hex_r0"}, r0, seg_tab[m_hr[k] % 10]);
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      model_step();
      @(posedge clk);
      #1;
      if (valid) begin
        check_dut("a_", 0, ia.serve_req, ia.serve_dir, ia.score_left, ia.score_right, ia.game_over,
                  ia.winner, ia.hex_l1, ia.hex_l0, ia.hex_r1, ia.hex_r0);
        check_dut("b_", 1, ib.serve_req, ib.serve_dir, ib.score_left, ib.score_right, ib.game_over,
                  ib.winner, ib.hex_l1, ib.hex_l0, ib.hex_r1, ib.hex_r0);
      end
    end
  endtask
  task automatic serve_latency(input string name, input int k);
    int c = 0;
    do begin
      tick(1);
      c++;
    end while (!(k == 1 ? ib.serve_req : ia.serve_req) && c < 20);
    chk(name, c, SD + 1);
  endtask
  typedef struct {
    bit rst_n;
    bit ng;
    logic [9:0] bx;
    int n;
    logic [7:0] a_sl, a_sr, b_sl, b_sr;
    bit b_go, b_win;
  } vec_t;
  vec_t tab[$];
  initial begin
    tab.push_back('{1'b0, 1'b0, 10'd320, 2,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
    tab.push_back('{1'b1, 1'b0, 10'd320, 6,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
    tab.push_back('{1'b1, 1'b0, 10'd100, 1,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
    tab.push_back('{1'b1, 1'b0, 10'd3,   1,  8'h00, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0});
    tab.push_back('{1'b1, 1'b0, 10'd3,   20, 8'h00, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0});
    tab.push_back('{1'b1, 1'b0, 10'd320, 6,  8'h00, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0});
    tab.push_back('{1'b1, 1'b0, 10'd0,   1,  8'h00, 8'h02, 8'h00, 8'h02, 1'b0, 1'b0});
    tab.push_back('{1'b1, 1'b0, 10'd320, 6,  8'h00, 8'h02, 8'h00, 8'h02, 1'b0, 1'b0});
    tab.push_back('{1'b1, 1'b0, 10'd0,   1,  8'h00, 8'h03, 8'h00, 8'h03, 1'b1, 1'b1});
    tab.push_back('{1'b1, 1'b0, 10'd320, 6,  8'h00, 8'h03, 8'h00, 8'h03, 1'b1, 1'b1});
    tab.push_back('{1'b1, 1'b0, 10'd639, 1,  8'h01, 8'h03, 8'h00, 8'h03, 1'b1, 1'b1});
    tab.push_back('{1'b1, 1'b0, 10'd320, 6,  8'h01, 8'h03, 8'h00, 8'h03, 1'b1, 1'b1});
    tab.push_back('{1'b1, 1'b0, 10'd0,   1,  8'h01, 8'h04, 8'h00, 8'h03, 1'b1, 1'b1});
    foreach (tab[i]) begin
      rst_n = tab[i].rst_n;
      ng = tab[i].ng;
      bx = tab[i].bx;
      tick(tab[i].n);
      chk($sformatf("vec%0d_a_score_left", i), ia.score_left, tab[i].a_sl);
      chk($sformatf("vec%0d_a_score_right", i), ia.score_right, tab[i].a_sr);
      chk($sformatf("vec%0d_b_score_left", i), ib.score_left, tab[i].b_sl);
      chk($sformatf("vec%0d_b_score_right", i), ib.score_right, tab[i].b_sr);
      chk($sformatf("vec%0d_b_game_over", i), ib.game_over, tab[i].b_go);
      chk($sformatf("vec%0d_b_winner", i), ib.winner, tab[i].b_win);
    end
    ng = 1'b1;
    bx = 10'd320;
    tick(1);
    ng = 1'b0;
    chk("over_ng_score_left", ib.score_left, 8'h00);
    chk("over_ng_score_right", ib.score_right, 8'h00);
    chk("over_ng_game_over", ib.game_over, 1'b0);
    serve_latency("over_ng_serve_latency", 1);
    ng = 1'b1;
    bx = 10'd0;
    tick(1);
    ng = 1'b0;
    chk("ng_goal_a_score_right", ia.score_right, 8'h00);
    chk("ng_goal_a_score_left", ia.score_left, 8'h00);
    chk("ng_goal_b_score_right", ib.score_right, 8'h00);
    bx = 10'd320;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("midrst_serve_req", ia.serve_req, 1'b0);
    chk("midrst_hex_l0", ia.hex_l0, 7'b1000000);
    chk("midrst_hex_l1", ia.hex_l1, 7'b1111111);
    chk("midrst_game_over", ia.game_over, 1'b0);
    serve_latency("midrst_serve_latency", 0);
    for (int g = 1; g <= 10; g++) begin
      bx = 10'd320;
      tick(6);
      bx = 10'd639;
      tick(1);
      chk($sformatf("left_goal%0d_score", g), ia.score_left, bcd(g));
    end
    bx = 10'd320;
    tick(2);
    chk("ten_hex_l1", ia.hex_l1, 7'b1111001);
    chk("ten_hex_l0", ia.hex_l0, 7'b1000000);
    chk("ten_score_left", ia.score_left, 8'h10);
    repeat (600) begin
      int r = $urandom_range(0, 99);
      bx = r < 20 ? 10'($urandom_range(0, 6)) : r < 40 ? 10'($urandom_range(620, 639)) : 10'($urandom_range(300, 340));
      ng = $urandom_range(0, 59) == 0;
      rst_n = $urandom_range(0, 149) != 0;
      tick($urandom_range(1, 8));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
